// File: rtl/render_pkg.sv
// Shared constants and types for the overlay renderer and its bounding-box accumulator.
package render_pkg;

    localparam int CW = 12;

    localparam logic [23:0] MASK_COLOR  = 24'h00FF00;
    localparam logic [23:0] BOX_COLOR   = 24'hFF00FF;
    localparam logic [23:0] CROSS_COLOR = 24'hFF0000;
    localparam logic [23:0] BBOX_COLOR  = 24'hFFFF00;

    typedef struct packed {
        logic [CW-1:0]   hmin;
        logic [CW-1:0]   hmax;
        logic [CW-1:0]   vmin;
        logic [CW-1:0]   vmax;
        logic [2*CW-1:0] cnt;
    } bbox_t;

    // Listed highest priority first.
    typedef enum logic [1:0] {
        OV_BOX,
        OV_CROSS,
        OV_BBOX,
        OV_BASE
    } overlay_e;

endpackage

// File: rtl/bbox_accum.sv
// Per-frame mask bounding box / pixel count accumulator with frame-boundary latch.
module bbox_accum
    import render_pkg::*;
#(
    parameter int H_ACT   = 640,
    parameter int V_ACT   = 480,
    parameter int MIN_PIX = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        sof,
    input  logic                        de,
    input  logic                        bin,
    input  logic [render_pkg::CW-1:0]   hcnt,
    input  logic [render_pkg::CW-1:0]   vcnt,
    output bbox_t                       bbox,
    output logic                        valid
);

    localparam bbox_t EMPTY = '{
        hmin: render_pkg::CW'(H_ACT - 1),
        hmax: '0,
        vmin: render_pkg::CW'(V_ACT - 1),
        vmax: '0,
        cnt:  '0
    };
    localparam bbox_t SEED = '{hmin: '0, hmax: '0, vmin: '0, vmax: '0, cnt: (2*render_pkg::CW)'(1)};

    bbox_t acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc   <= EMPTY;
            bbox  <= '0;
            valid <= 1'b0;
        end else if (sof) begin
            // Latch the finished frame and restart, counting the (0,0) pixel itself.
            bbox  <= acc;
            valid <= (acc.cnt >= (2*render_pkg::CW)'(MIN_PIX));
            acc   <= bin ? SEED : EMPTY;
        end else if (de && bin) begin
            acc.hmin <= (hcnt < acc.hmin) ? hcnt : acc.hmin;
            acc.hmax <= (hcnt > acc.hmax) ? hcnt : acc.hmax;
            acc.vmin <= (vcnt < acc.vmin) ? vcnt : acc.vmin;
            acc.vmax <= (vcnt > acc.vmax) ? vcnt : acc.vmax;
            acc.cnt  <= (&acc.cnt) ? acc.cnt : acc.cnt + 1'b1;
        end
    end

endmodule

// File: rtl/render_overlay.sv
// Two-stage pixel renderer: mask recolour, capture box, crosshair and previous-frame bbox outline.
// Optional crosshair blinking is enabled by defining RENDER_OVERLAY_BLINK_EN.
module render_overlay
    import render_pkg::*;
#(
    parameter int          CW          = render_pkg::CW,
    parameter int          H_ACT       = 640,
    parameter int          V_ACT       = 480,
    parameter int          BOX_HALF    = 24,
    parameter int          MIN_PIX     = 16,
    parameter logic [23:0] MASK_COLOR  = render_pkg::MASK_COLOR,
    parameter logic [23:0] BOX_COLOR   = render_pkg::BOX_COLOR,
    parameter logic [23:0] CROSS_COLOR = render_pkg::CROSS_COLOR,
    parameter logic [23:0] BBOX_COLOR  = render_pkg::BBOX_COLOR
) (
    input  logic            PClk,
    input  logic            Rst_n,
    input  logic            De_in,
    input  logic [23:0]     RGB24,
    input  logic            Binary_in,
    input  logic [CW-1:0]   VtcHCnt,
    input  logic [CW-1:0]   VtcVCnt,
    input  logic [CW-1:0]   center_h,
    input  logic [CW-1:0]   center_v,
    output logic [23:0]     RGB_render,
    output logic            De_out,
    output logic [CW-1:0]   bbox_hmin,
    output logic [CW-1:0]   bbox_hmax,
    output logic [CW-1:0]   bbox_vmin,
    output logic [CW-1:0]   bbox_vmax,
    output logic [2*CW-1:0] bbox_cnt,
    output logic            bbox_valid
);

    localparam logic [CW-1:0] BX_L = CW'(H_ACT/2 - BOX_HALF);
    localparam logic [CW-1:0] BX_R = CW'(H_ACT/2 + BOX_HALF);
    localparam logic [CW-1:0] BY_T = CW'(V_ACT/2 - BOX_HALF);
    localparam logic [CW-1:0] BY_B = CW'(V_ACT/2 + BOX_HALF);

    logic          sof;
    bbox_t         bb;
    logic          cross_en;
    logic [2:1]    vld_pipe;
    logic [23:0]   s1_rgb;
    logic [CW-1:0] s1_h, s1_v, s1_ch, s1_cv;

    assign sof = De_in && (VtcHCnt == '0) && (VtcVCnt == '0);

    bbox_accum #(
        .H_ACT   (H_ACT),
        .V_ACT   (V_ACT),
        .MIN_PIX (MIN_PIX)
    ) u_bbox (
        .clk   (PClk),
        .rst_n (Rst_n),
        .sof   (sof),
        .de    (De_in),
        .bin   (Binary_in),
        .hcnt  (VtcHCnt),
        .vcnt  (VtcVCnt),
        .bbox  (bb),
        .valid (bbox_valid)
    );

    assign bbox_hmin = bb.hmin;
    assign bbox_hmax = bb.hmax;
    assign bbox_vmin = bb.vmin;
    assign bbox_vmax = bb.vmax;
    assign bbox_cnt  = bb.cnt;

`ifdef RENDER_OVERLAY_BLINK_EN
    logic [5:0] frame_cnt;

    always_ff @(posedge PClk or negedge Rst_n) begin
        if (!Rst_n)
            frame_cnt <= '0;
        else if (sof)
            frame_cnt <= frame_cnt + 1'b1;
    end

    assign cross_en = ~frame_cnt[5];
`else
    assign cross_en = 1'b1;
`endif

    // Stage 1: base colour and registered coordinates.
    always_ff @(posedge PClk or negedge Rst_n) begin
        if (!Rst_n) begin
            vld_pipe <= '0;
            s1_rgb   <= '0;
            s1_h     <= '0;
            s1_v     <= '0;
            s1_ch    <= '0;
            s1_cv    <= '0;
        end else begin
            vld_pipe <= {vld_pipe[1], De_in};
            s1_rgb   <= (Binary_in && De_in) ? MASK_COLOR : RGB24;
            s1_h     <= VtcHCnt;
            s1_v     <= VtcVCnt;
            s1_ch    <= center_h;
            s1_cv    <= center_v;
        end
    end

    logic     on_box, on_cross, on_bbox;
    overlay_e ov;
    logic [23:0] color;

    assign on_box = ((s1_h == BX_L || s1_h == BX_R) && s1_v >= BY_T && s1_v <= BY_B) ||
                    ((s1_v == BY_T || s1_v == BY_B) && s1_h >= BX_L && s1_h <= BX_R);

    assign on_cross = cross_en && (s1_h == s1_ch || s1_v == s1_cv);

    // Only the latched box is drawn; an invalid latch holds sentinels that must stay hidden.
    assign on_bbox = bbox_valid &&
                     (((s1_h == bb.hmin || s1_h == bb.hmax) && s1_v >= bb.vmin && s1_v <= bb.vmax) ||
                      ((s1_v == bb.vmin || s1_v == bb.vmax) && s1_h >= bb.hmin && s1_h <= bb.hmax));

    always_comb begin
        ov = OV_BASE;
        if (on_bbox)  ov = OV_BBOX;
        if (on_cross) ov = OV_CROSS;
        if (on_box)   ov = OV_BOX;
        case (ov)
            OV_BOX:   color = BOX_COLOR;
            OV_CROSS: color = CROSS_COLOR;
            OV_BBOX:  color = BBOX_COLOR;
            default:  color = s1_rgb;
        endcase
    end

    // Stage 2: blank outside active video.
    always_ff @(posedge PClk or negedge Rst_n) begin
        if (!Rst_n)
            RGB_render <= '0;
        else
            RGB_render <= vld_pipe[1] ? color : 24'h0;
    end

    assign De_out = vld_pipe[2];

endmodule

// File: tb/tb_render_overlay.sv
// Scoreboarded bench for render_overlay: sparse frames driven by coordinate, default build.
module tb_render_overlay;

    logic        PClk = 1'b0;
    logic        Rst_n;
    logic        De_in;
    logic [23:0] RGB24;
    logic        Binary_in;
    logic [11:0] VtcHCnt, VtcVCnt, center_h, center_v;
    logic [23:0] RGB_render;
    logic        De_out;
    logic [11:0] bbox_hmin, bbox_hmax, bbox_vmin, bbox_vmax;
    logic [23:0] bbox_cnt;
    logic        bbox_valid;

    render_overlay dut (
        .PClk       (PClk),
        .Rst_n      (Rst_n),
        .De_in      (De_in),
        .RGB24      (RGB24),
        .Binary_in  (Binary_in),
        .VtcHCnt    (VtcHCnt),
        .VtcVCnt    (VtcVCnt),
        .center_h   (center_h),
        .center_v   (center_v),
        .RGB_render (RGB_render),
        .De_out     (De_out),
        .bbox_hmin  (bbox_hmin),
        .bbox_hmax  (bbox_hmax),
        .bbox_vmin  (bbox_vmin),
        .bbox_vmax  (bbox_vmax),
        .bbox_cnt   (bbox_cnt),
        .bbox_valid (bbox_valid)
    );

    always #5 PClk = ~PClk;

    int checks = 0;
    int errors = 0;
    int ch = 630, cv = 470;

    typedef struct {
        logic [24:0] exp;
        int          h;
        int          v;
    } sb_t;
    sb_t sb[$];

    typedef struct {
        int          h, v;
        logic        bin, de;
        logic [23:0] rgb;
        int          ch, cv;
        logic [23:0] exp;
    } vec_t;
    vec_t tab[16];

    // Reference state: in-progress accumulators and the latched previous frame.
    int a_hmin, a_hmax, a_vmin, a_vmax, a_cnt;
    int l_hmin, l_hmax, l_vmin, l_vmax, l_cnt;
    bit l_valid;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic acc_empty();
        a_hmin = 639; a_hmax = 0; a_vmin = 479; a_vmax = 0; a_cnt = 0;
    endtask

    task automatic model_reset();
        acc_empty();
        l_hmin = 0; l_hmax = 0; l_vmin = 0; l_vmax = 0; l_cnt = 0; l_valid = 0;
    endtask

    function automatic logic [23:0] exp_color(logic de, logic [23:0] rgb, logic bin, int h, int v, int xh, int xv);
        if (!de) return 24'h0;
        if (((h == 296 || h == 344) && v >= 216 && v <= 264) ||
            ((v == 216 || v == 264) && h >= 296 && h <= 344)) return 24'hFF00FF;
        if (h == xh || v == xv) return 24'hFF0000;
        if (l_valid && (((h == l_hmin || h == l_hmax) && v >= l_vmin && v <= l_vmax) ||
                        ((v == l_vmin || v == l_vmax) && h >= l_hmin && h <= l_hmax))) return 24'hFFFF00;
        return bin ? 24'h00FF00 : rgb;
    endfunction

    task automatic px(input logic de, input logic [23:0] rgb, input logic bin, input int h, input int v,
                      input logic use_tab, input logic [23:0] tab_exp);
        logic  sof;
        logic [23:0] e;
        sb_t   got;
        sof = de && h == 0 && v == 0;
        if (sof) begin
            l_hmin = a_hmin; l_hmax = a_hmax; l_vmin = a_vmin; l_vmax = a_vmax; l_cnt = a_cnt;
            l_valid = (a_cnt >= 16);
            if (bin) begin a_hmin = 0; a_hmax = 0; a_vmin = 0; a_vmax = 0; a_cnt = 1; end
            else acc_empty();
        end
        e = use_tab ? tab_exp : exp_color(de, rgb, bin, h, v, ch, cv);
        if (!sof && de && bin) begin
            if (h < a_hmin) a_hmin = h;
            if (h > a_hmax) a_hmax = h;
            if (v < a_vmin) a_vmin = v;
            if (v > a_vmax) a_vmax = v;
            a_cnt++;
        end
        De_in = de; RGB24 = rgb; Binary_in = bin;
        VtcHCnt = 12'(h); VtcVCnt = 12'(v);
        center_h = 12'(ch); center_v = 12'(cv);
        sb.push_back('{exp: {de, e}, h: h, v: v});
        @(posedge PClk);
        #1;
        if (sb.size() >= 2) begin
            got = sb.pop_front();
            chk($sformatf("pixel(%0d,%0d) {de,rgb}", got.h, got.v), {7'd0, De_out, RGB_render}, {7'd0, got.exp});
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) px(1'b0, 24'h0, 1'b0, 700, 700, 1'b0, 24'h0);
    endtask

    task automatic chk_bbox(input string tag, input int hmin, input int hmax, input int vmin,
                            input int vmax, input int cnt, input logic valid);
        chk({tag, " hmin"},  {20'd0, bbox_hmin}, hmin);
        chk({tag, " hmax"},  {20'd0, bbox_hmax}, hmax);
        chk({tag, " vmin"},  {20'd0, bbox_vmin}, vmin);
        chk({tag, " vmax"},  {20'd0, bbox_vmax}, vmax);
        chk({tag, " cnt"},   {8'd0, bbox_cnt}, cnt);
        chk({tag, " valid"}, {31'd0, bbox_valid}, {31'd0, valid});
    endtask

    initial begin
        tab[0]  = '{h: 100, v: 55,  bin: 0, de: 1, rgb: 24'h123456, ch: 630, cv: 470, exp: 24'hFFFF00};
        tab[1]  = '{h: 105, v: 59,  bin: 0, de: 1, rgb: 24'h123456, ch: 630, cv: 470, exp: 24'hFFFF00};
        tab[2]  = '{h: 109, v: 50,  bin: 0, de: 1, rgb: 24'h123456, ch: 630, cv: 470, exp: 24'hFFFF00};
        tab[3]  = '{h: 105, v: 55,  bin: 0, de: 1, rgb: 24'h123456, ch: 630, cv: 470, exp: 24'h123456};
        tab[4]  = '{h: 99,  v: 55,  bin: 0, de: 1, rgb: 24'h123456, ch: 630, cv: 470, exp: 24'h123456};
        tab[5]  = '{h: 110, v: 59,  bin: 0, de: 1, rgb: 24'h123456, ch: 630, cv: 470, exp: 24'h123456};
        tab[6]  = '{h: 102, v: 52,  bin: 1, de: 1, rgb: 24'h123456, ch: 630, cv: 470, exp: 24'h00FF00};
        tab[7]  = '{h: 296, v: 240, bin: 0, de: 1, rgb: 24'h123456, ch: 296, cv: 240, exp: 24'hFF00FF};
        tab[8]  = '{h: 296, v: 300, bin: 0, de: 1, rgb: 24'h123456, ch: 296, cv: 240, exp: 24'hFF0000};
        tab[9]  = '{h: 320, v: 216, bin: 0, de: 1, rgb: 24'h123456, ch: 630, cv: 470, exp: 24'hFF00FF};
        tab[10] = '{h: 344, v: 264, bin: 0, de: 1, rgb: 24'h123456, ch: 630, cv: 470, exp: 24'hFF00FF};
        tab[11] = '{h: 345, v: 240, bin: 0, de: 1, rgb: 24'h123456, ch: 630, cv: 470, exp: 24'h123456};
        tab[12] = '{h: 320, v: 240, bin: 0, de: 1, rgb: 24'h123456, ch: 630, cv: 470, exp: 24'h123456};
        tab[13] = '{h: 100, v: 55,  bin: 0, de: 1, rgb: 24'h123456, ch: 100, cv: 470, exp: 24'hFF0000};
        tab[14] = '{h: 100, v: 55,  bin: 0, de: 0, rgb: 24'h123456, ch: 630, cv: 470, exp: 24'h000000};
        tab[15] = '{h: 200, v: 100, bin: 1, de: 1, rgb: 24'hABCDEF, ch: 630, cv: 470, exp: 24'h00FF00};

        Rst_n = 1'b0; De_in = 1'b0; RGB24 = '0; Binary_in = 1'b0;
        VtcHCnt = '0; VtcVCnt = '0; center_h = 12'(ch); center_v = 12'(cv);
        model_reset();
        repeat (3) @(posedge PClk);
        #1;
        chk("reset RGB_render", {8'd0, RGB_render}, 0);
        chk("reset De_out", {31'd0, De_out}, 0);
        chk_bbox("reset", 0, 0, 0, 0, 0, 1'b0);
        #1 Rst_n = 1'b1;

        // Frame A: 10x10 mask block; first boundary latches the empty sentinels.
        px(1'b1, 24'h123456, 1'b0, 0, 0, 1'b0, 24'h0);
        chk_bbox("first latch", 639, 0, 479, 0, 0, 1'b0);
        for (int v = 50; v <= 59; v++)
            for (int h = 98; h <= 111; h++)
                px(1'b1, 24'h123456, (h >= 100 && h <= 109), h, v, 1'b0, 24'h0);
        idle(2);

        // Frame B: outline drawn, priorities, 15 mask pixels in total.
        px(1'b1, 24'h123456, 1'b0, 0, 0, 1'b0, 24'h0);
        chk_bbox("block frame", 100, 109, 50, 59, 100, 1'b1);
        for (int i = 0; i < 16; i++) begin
            ch = tab[i].ch; cv = tab[i].cv;
            px(tab[i].de, tab[i].rgb, tab[i].bin, tab[i].h, tab[i].v, 1'b1, tab[i].exp);
        end
        ch = 630; cv = 470;
        for (int h = 10; h <= 22; h++) px(1'b1, 24'h123456, 1'b1, h, 400, 1'b0, 24'h0);
        idle(2);

        // Frame C: 15 pixels is below threshold, nothing drawn; then 16 mask pixels.
        px(1'b1, 24'h123456, 1'b0, 0, 0, 1'b0, 24'h0);
        chk_bbox("15 pixels", 10, 200, 52, 400, 15, 1'b0);
        px(1'b1, 24'h123456, 1'b0, 10, 200, 1'b1, 24'h123456);
        px(1'b1, 24'h123456, 1'b0, 200, 100, 1'b1, 24'h123456);
        for (int h = 10; h <= 25; h++) px(1'b1, 24'h123456, 1'b1, h, 410, 1'b0, 24'h0);
        idle(2);

        // Frame D: seeded by a masked (0,0); previous frame latched at the same boundary.
        px(1'b1, 24'h123456, 1'b1, 0, 0, 1'b0, 24'h0);
        chk_bbox("16 pixels", 10, 25, 410, 410, 16, 1'b1);
        px(1'b1, 24'h123456, 1'b0, 10, 410, 1'b1, 24'hFFFF00);
        px(1'b1, 24'h123456, 1'b0, 17, 410, 1'b1, 24'hFFFF00);
        px(1'b1, 24'h123456, 1'b0, 9, 410, 1'b1, 24'h123456);
        idle(2);

        // Frame E: seed-only frame latched; add 20 mask pixels for a valid box.
        px(1'b1, 24'h123456, 1'b0, 0, 0, 1'b0, 24'h0);
        chk_bbox("seed only", 0, 0, 0, 0, 1, 1'b0);
        for (int h = 400; h <= 419; h++) px(1'b1, 24'h654321, 1'b1, h, 300, 1'b0, 24'h0);
        idle(2);

        // Frame F: outline on row 300, then reset mid-frame.
        px(1'b1, 24'h123456, 1'b0, 0, 0, 1'b0, 24'h0);
        chk_bbox("row frame", 400, 419, 300, 300, 20, 1'b1);
        for (int h = 398; h <= 421; h++) px(1'b1, 24'h654321, (h % 2 == 0), h, 300, 1'b0, 24'h0);
        chk("pre-reset De_out", {31'd0, De_out}, 1);
        #1 Rst_n = 1'b0;
        De_in = 1'b0;
        #1;
        chk("async reset RGB_render", {8'd0, RGB_render}, 0);
        chk("async reset De_out", {31'd0, De_out}, 0);
        chk("async reset bbox_valid", {31'd0, bbox_valid}, 0);
        sb.delete();
        model_reset();
        repeat (2) @(posedge PClk);
        #2 Rst_n = 1'b1;

        // Accumulators were discarded: the next boundary latches an empty frame.
        px(1'b1, 24'h123456, 1'b0, 0, 0, 1'b0, 24'h0);
        chk_bbox("after reset", 639, 0, 479, 0, 0, 1'b0);
        px(1'b1, 24'h123456, 1'b0, 400, 300, 1'b1, 24'h123456);
        idle(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
